traffic_intersection_ctrl: RTL and testbench
============================================

Name: traffic_intersection_ctrl

Overview:
- Sequencing controller for a two-road intersection (north-south NS, east-west EW). It drives one red/green/yellow lamp set per road.
- Green time per road is extended under heavy-traffic conditions.
- Pedestrian requests are latched and served in a walk phase in which all lamps are red.
- An emergency input forces a safe all-red hold.
- The block sits above the single-light lamp logic and owns all phase timing for the intersection.

Parameters:
- CW, 6, counter width; every *_TICKS value must be at most 2^CW-1.
- GREEN_TICKS, 31, normal green terminal count (phase lasts GREEN_TICKS+1 cycles).
- GREEN_EXT_TICKS, 63, extended green terminal count when the road's heavy input is high.
- YELLOW_TICKS, 4, yellow terminal count.
- ALLRED_TICKS, 2, all-red clearance terminal count.
- WALK_TICKS, 15, pedestrian walk terminal count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- heavy_ns  in  1  level; extends NS green.
- heavy_ew  in  1  level; extends EW green.
- ped_req  in  1  pedestrian request; any cycle high sets the pending flag.
- emerg  in  1  level; emergency all-red request.
- ns_red, ns_yellow, ns_green  out  1 each  NS lamps; exactly one is high.
- ew_red, ew_yellow, ew_green  out  1 each  EW lamps; exactly one is high.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  registered pending-request flag.
- phase  out  3  current state encoding, for debug and verification.

Behaviour:
- States and encodings: AR_NS=0, NS_G=1, NS_Y=2, AR_EW=3, EW_G=4, EW_Y=5, WALK=6, EMERG=7.
- Single phase counter cnt[CW-1:0]:
  - cnt is cleared on every state change.
  - Otherwise cnt increments.
  - A state ends on the cycle where cnt >= its terminal count (the comparison is >=, not ==).
- Terminal counts per state:
  - NS_G: heavy_ns ? GREEN_EXT_TICKS : GREEN_TICKS, evaluated every cycle. If heavy drops while cnt > GREEN_TICKS, the phase ends on that cycle.
  - EW_G: same rule using heavy_ew.
  - NS_Y and EW_Y: YELLOW_TICKS.
  - AR_NS and AR_EW: ALLRED_TICKS.
  - WALK: WALK_TICKS.
- Normal sequence: AR_NS -> NS_G -> NS_Y -> AR_EW -> EW_G -> EW_Y -> (ped_pending ? WALK : AR_NS). WALK -> AR_NS.
- Reset: state=AR_NS, cnt=0, ped_pending=0. Reset outputs are ns_red=1, ew_red=1, all other lamps and walk=0, phase=0. Reset mid-phase aborts the phase immediately on the next edge.
- Lamp decode is combinational from state:
  - AR_NS, AR_EW, WALK and EMERG: both roads red.
  - NS_G / NS_Y: NS green / yellow with EW red.
  - EW_G / EW_Y: EW green / yellow with NS red.
  - walk=1 only in WALK.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the edge entering WALK.
  - If ped_req=1 on that same edge, set wins and the flag stays 1.
  - Not cleared by EMERG.
- emerg, sampled each cycle; it has priority over normal termination:
  - In NS_G or EW_G: next state is the matching yellow, cnt=0.
  - In NS_Y or EW_Y: yellow runs to completion, then goes to EMERG instead of the normal successor.
  - In AR_NS, AR_EW or WALK: EMERG on the next edge. A WALK cut short this way does not re-set ped_pending.
  - In EMERG: state holds while emerg=1. When emerg=0, the next state is AR_NS with cnt=0.
- Safety invariant: a green on both roads at once is never allowed, and no green phase follows a green phase without an intervening yellow and an all-red state.

Test Plan:
- Reset then idle (all inputs 0):
  - AR_NS lasts 3 cycles, NS_G 32, NS_Y 5, AR_EW 3, EW_G 32, EW_Y 5, then AR_NS; full period is 80 cycles.
  - Exactly one lamp is high per road on every cycle.
- heavy_ns=1 throughout: NS_G lasts 64 cycles.
  - Drop heavy_ns when NS_G cnt=40: NS_Y is entered on the next edge.
- Pulse ped_req for 1 cycle during NS_G:
  - ped_pending rises on the next edge.
  - After EW_Y the controller enters WALK for 16 cycles with walk=1 and all lamps red.
  - ped_pending clears on WALK entry; then AR_NS.
- Hold ped_req=1 on the WALK-entry edge: ped_pending stays 1 and a second WALK follows the next EW_Y.
- emerg asserted at EW_G cnt=10: EW_Y for 5 cycles, then EMERG (phase=7, all red).
  - Release emerg after 20 cycles: AR_NS on the next edge, then normal NS_G.
- rst asserted mid-EW_Y: next cycle state=AR_NS, cnt=0, ped_pending=0, ns_red=ew_red=1.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer: NS/EW lamp phases with heavy-traffic green extension,
// latched pedestrian walk phase and an emergency all-red hold.
module traffic_intersection_ctrl #(
  parameter int unsigned CW              = 6,
  parameter int unsigned GREEN_TICKS     = 31,
  parameter int unsigned GREEN_EXT_TICKS = 63,
  parameter int unsigned YELLOW_TICKS    = 4,
  parameter int unsigned ALLRED_TICKS    = 2,
  parameter int unsigned WALK_TICKS      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       heavy_ns,
  input  logic       heavy_ew,
  input  logic       ped_req,
  input  logic       emerg,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StArNs  = 3'd0,
    StNsG   = 3'd1,
    StNsY   = 3'd2,
    StArEw  = 3'd3,
    StEwG   = 3'd4,
    StEwY   = 3'd5,
    StWalk  = 3'd6,
    StEmerg = 3'd7
  } state_e;

  localparam logic [CW-1:0] GreenT    = CW'(GREEN_TICKS);
  localparam logic [CW-1:0] GreenExtT = CW'(GREEN_EXT_TICKS);
  localparam logic [CW-1:0] YellowT   = CW'(YELLOW_TICKS);
  localparam logic [CW-1:0] AllRedT   = CW'(ALLRED_TICKS);
  localparam logic [CW-1:0] WalkT     = CW'(WALK_TICKS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          ped_pending_q;
  logic [CW-1:0] term;
  logic          done;

  // Terminal count is re-evaluated every cycle so a heavy input dropping late ends green at once.
  always_comb begin
    term = '1;
    unique case (state_q)
      StArNs, StArEw: term = AllRedT;
      StNsG:          term = heavy_ns ? GreenExtT : GreenT;
      StEwG:          term = heavy_ew ? GreenExtT : GreenT;
      StNsY, StEwY:   term = YellowT;
      StWalk:         term = WalkT;
      default:        term = '1;
    endcase
  end

  assign done = (cnt_q >= term);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArNs: begin
        if (emerg)     state_d = StEmerg;
        else if (done) state_d = StNsG;
      end
      StNsG:   if (emerg || done) state_d = StNsY;
      StNsY:   if (done) state_d = emerg ? StEmerg : StArEw;
      StArEw: begin
        if (emerg)     state_d = StEmerg;
        else if (done) state_d = StEwG;
      end
      StEwG:   if (emerg || done) state_d = StEwY;
      StEwY: begin
        if (done) begin
          if (emerg)              state_d = StEmerg;
          else if (ped_pending_q) state_d = StWalk;
          else                    state_d = StArNs;
        end
      end
      StWalk: begin
        if (emerg)     state_d = StEmerg;
        else if (done) state_d = StArNs;
      end
      StEmerg: if (!emerg) state_d = StArNs;
      default: state_d = StArNs;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StArNs;
      cnt_q         <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      // A new request on the WALK-entry edge must survive the clear.
      if (ped_req)                                        ped_pending_q <= 1'b1;
      else if (state_d == StWalk && state_q != StWalk)    ped_pending_q <= 1'b0;
    end
  end

  always_comb begin
    ns_red    = 1'b1;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b1;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    walk      = 1'b0;
    unique case (state_q)
      StNsG:  begin ns_red = 1'b0; ns_green  = 1'b1; end
      StNsY:  begin ns_red = 1'b0; ns_yellow = 1'b1; end
      StEwG:  begin ew_red = 1'b0; ew_green  = 1'b1; end
      StEwY:  begin ew_red = 1'b0; ew_yellow = 1'b1; end
      StWalk: walk = 1'b1;
      default: ;
    endcase
  end

  assign ped_pending = ped_pending_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed segment-table bench for traffic_intersection_ctrl: each record holds inputs,
// expected phase/pending flag and how many cycles that phase must persist.
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       heavy_ns, heavy_ew, ped_req, emerg;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_pending;
  logic [2:0] phase;

  traffic_intersection_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .heavy_ns   (heavy_ns),
    .heavy_ew   (heavy_ew),
    .ped_req    (ped_req),
    .emerg      (emerg),
    .ns_red     (ns_red),
    .ns_yellow  (ns_yellow),
    .ns_green   (ns_green),
    .ew_red     (ew_red),
    .ew_yellow  (ew_yellow),
    .ew_green   (ew_green),
    .walk       (walk),
    .ped_pending(ped_pending),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hn;
    logic       he;
    logic       pr;
    logic       em;
    logic [2:0] ph;
    logic       pend;
    int         len;
  } seg_t;

  seg_t segs[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [2:0] ArNs = 3'd0, NsG = 3'd1, NsY = 3'd2, ArEw = 3'd3;
  localparam logic [2:0] EwG = 3'd4, EwY = 3'd5, Wlk = 3'd6, Emg = 3'd7;

  task automatic add(input logic hn, input logic he, input logic pr, input logic em,
                     input logic [2:0] ph, input logic pend, input int len);
    seg_t s;
    s.hn = hn; s.he = he; s.pr = pr; s.em = em; s.ph = ph; s.pend = pend; s.len = len;
    segs.push_back(s);
  endtask

  // Expected {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk} for a given phase.
  function automatic logic [6:0] lamps_for(input logic [2:0] ph);
    case (ph)
      NsG:     return 7'b001_100_0;
      NsY:     return 7'b010_100_0;
      EwG:     return 7'b100_001_0;
      EwY:     return 7'b100_010_0;
      Wlk:     return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input int cyc, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s seg=%0d cyc=%0d actual=%0h required=%0h", name, idx, cyc, act, exp);
    end
  endtask

  task automatic check_state(input int idx, input int cyc, input logic [2:0] ph,
                             input logic pend);
    chk("phase", idx, cyc, int'(phase), int'(ph));
    chk("lamps", idx, cyc,
        int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}),
        int'(lamps_for(ph)));
    chk("ped_pending", idx, cyc, int'(ped_pending), int'(pend));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; heavy_ns = 1'b0; heavy_ew = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    step();
    step();
    check_state(-1, 0, ArNs, 1'b0);
    rst = 1'b0;

    // Idle: full 80-cycle period.
    add(0,0,0,0, ArNs, 0, 3);  add(0,0,0,0, NsG, 0, 32); add(0,0,0,0, NsY, 0, 5);
    add(0,0,0,0, ArEw, 0, 3);  add(0,0,0,0, EwG, 0, 32); add(0,0,0,0, EwY, 0, 5);
    // Heavy NS throughout green: 64 cycles.
    add(0,0,0,0, ArNs, 0, 3);  add(1,0,0,0, NsG, 0, 64); add(0,0,0,0, NsY, 0, 5);
    add(0,0,0,0, ArEw, 0, 3);  add(0,1,0,0, EwG, 0, 64); add(0,0,0,0, EwY, 0, 5);
    // Heavy NS dropped at cnt=40: yellow on the next edge.
    add(0,0,0,0, ArNs, 0, 3);  add(1,0,0,0, NsG, 0, 40); add(0,0,0,0, NsG, 0, 1);
    add(0,0,0,0, NsY, 0, 5);   add(0,0,0,0, ArEw, 0, 3); add(0,0,0,0, EwG, 0, 32);
    add(0,0,0,0, EwY, 0, 5);
    // Single-cycle ped request during NS_G, served after EW_Y.
    add(0,0,0,0, ArNs, 0, 3);  add(0,0,1,0, NsG, 0, 1);  add(0,0,0,0, NsG, 1, 31);
    add(0,0,0,0, NsY, 1, 5);   add(0,0,0,0, ArEw, 1, 3); add(0,0,0,0, EwG, 1, 32);
    add(0,0,0,0, EwY, 1, 5);   add(0,0,0,0, Wlk, 0, 16);
    // Request held on the WALK-entry edge: pending survives, second WALK follows.
    add(0,0,0,0, ArNs, 0, 3);  add(0,0,1,0, NsG, 0, 1);  add(0,0,0,0, NsG, 1, 31);
    add(0,0,0,0, NsY, 1, 5);   add(0,0,0,0, ArEw, 1, 3); add(0,0,0,0, EwG, 1, 32);
    add(0,0,0,0, EwY, 1, 4);   add(0,0,1,0, EwY, 1, 1);  add(0,0,0,0, Wlk, 1, 16);
    add(0,0,0,0, ArNs, 1, 3);  add(0,0,0,0, NsG, 1, 32); add(0,0,0,0, NsY, 1, 5);
    add(0,0,0,0, ArEw, 1, 3);  add(0,0,0,0, EwG, 1, 32); add(0,0,0,0, EwY, 1, 5);
    add(0,0,0,0, Wlk, 0, 16);
    // Emergency at EW_G cnt=10: yellow completes, then EMERG hold for 20 cycles.
    add(0,0,0,0, ArNs, 0, 3);  add(0,0,0,0, NsG, 0, 32); add(0,0,0,0, NsY, 0, 5);
    add(0,0,0,0, ArEw, 0, 3);  add(0,0,0,0, EwG, 0, 10); add(0,0,0,1, EwG, 0, 1);
    add(0,0,0,1, EwY, 0, 5);   add(0,0,0,1, Emg, 0, 19); add(0,0,0,0, Emg, 0, 1);
    add(0,0,0,0, ArNs, 0, 3);  add(0,0,0,0, NsG, 0, 32); add(0,0,0,0, NsY, 0, 5);
    // Emergency during AR_EW goes straight to EMERG.
    add(0,0,0,1, ArEw, 0, 1);  add(0,0,0,0, Emg, 0, 1);
    // Pending set before a reset that lands mid-EW_Y.
    add(0,0,0,0, ArNs, 0, 3);  add(0,0,0,0, NsG, 0, 32); add(0,0,0,0, NsY, 0, 5);
    add(0,0,0,0, ArEw, 0, 3);  add(0,0,1,0, EwG, 0, 1);  add(0,0,0,0, EwG, 1, 31);
    add(0,0,0,0, EwY, 1, 2);

    foreach (segs[i]) begin
      for (int c = 0; c < segs[i].len; c++) begin
        heavy_ns = segs[i].hn; heavy_ew = segs[i].he;
        ped_req  = segs[i].pr; emerg    = segs[i].em;
        check_state(i, c, segs[i].ph, segs[i].pend);
        step();
      end
    end

    // Reset mid-EW_Y: aborts to AR_NS with cleared count and pending flag.
    heavy_ns = 1'b0; heavy_ew = 1'b0; ped_req = 1'b0; emerg = 1'b0;
    check_state(1000, 0, EwY, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state(1001, 0, ArNs, 1'b0);
    step();
    check_state(1001, 1, ArNs, 1'b0);
    step();
    check_state(1001, 2, ArNs, 1'b0);
    step();
    check_state(1002, 0, NsG, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
